// File: rtl/mux_scan_serializer.sv
// mux_scan_serializer
//   Walks a bit multiplexer's select across all N inputs and streams each
//   selected bit over a valid/ready serial interface. The frame is marked
//   with a last flag, followed by a one-cycle done pulse, and the frame's
//   even parity is reported.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      frame request, sampled only in IDLE
//   msb_first  scan order, sampled with start (1: N-1..0, 0: 0..N-1)
//   mux_sel    select driven to the external mux
//   mux_bit    mux output for the current mux_sel (same-cycle path)
//   ser_out    serial data bit
//   ser_valid  ser_out / ser_last valid
//   ser_last   final bit of the frame, qualified by ser_valid
//   ser_ready  downstream accept
//   busy       high while the frame is being shifted
//   done       one-cycle pulse after the last bit is accepted
//   parity     XOR of all bits of the most recent frame
//
// Handshake: a bit transfers on any rising edge where ser_valid and
// ser_ready are both high. Once ser_valid rises, ser_out and ser_last stay
// constant until that transfer. ser_valid never drops without a transfer.
module mux_scan_serializer #(
  parameter int N     = 16,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             msb_first,
  output logic [SEL_W-1:0] mux_sel,
  input  logic             mux_bit,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  input  logic             ser_ready,
  output logic             busy,
  output logic             done,
  output logic             parity
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0]    CNT_N    = CW'(N);
  localparam logic [CW-1:0]    CNT_LAST = CW'(N - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Exposed by name so checkers can bind to the FSM state.
  state_t state, state_nxt;

  logic [CW-1:0]    cnt, cnt_nxt;
  logic             mode, mode_nxt;
  logic [SEL_W-1:0] sel_nxt;
  logic             out_nxt, valid_nxt, last_nxt;
  logic             busy_nxt, done_nxt, parity_nxt;
  logic             load_slot;
  logic             xfer;

  assign xfer      = ser_valid & ser_ready;
  // The output register is free (empty or draining this edge) and bits remain.
  assign load_slot = (!ser_valid || ser_ready) && (cnt < CNT_N);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    mode_nxt   = mode;
    sel_nxt    = mux_sel;
    out_nxt    = ser_out;
    valid_nxt  = ser_valid;
    last_nxt   = ser_last;
    parity_nxt = parity;

    case (state)
      IDLE: begin
        if (start) begin
          mode_nxt   = msb_first;
          sel_nxt    = msb_first ? SEL_LAST : '0;
          parity_nxt = 1'b0;
          cnt_nxt    = '0;
          state_nxt  = SHIFT;
        end
      end

      SHIFT: begin
        if (xfer && ser_last) begin
          valid_nxt = 1'b0;
          last_nxt  = 1'b0;
          state_nxt = DONE;
        end else if (load_slot) begin
          out_nxt    = mux_bit;
          valid_nxt  = 1'b1;
          last_nxt   = (cnt == CNT_LAST);
          parity_nxt = parity ^ mux_bit;
          cnt_nxt    = cnt + CW'(1);
          // No step after the final load, so the select never leaves 0..N-1.
          if (cnt != CNT_LAST) begin
            sel_nxt = mode ? (mux_sel - SEL_W'(1)) : (mux_sel + SEL_W'(1));
          end
        end else if (xfer) begin
          valid_nxt = 1'b0;
          last_nxt  = 1'b0;
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt == SHIFT);
    done_nxt = (state_nxt == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      mode      <= 1'b0;
      mux_sel   <= '0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      ser_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      parity    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      mode      <= mode_nxt;
      mux_sel   <= sel_nxt;
      ser_out   <= out_nxt;
      ser_valid <= valid_nxt;
      ser_last  <= last_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      parity    <= parity_nxt;
    end
  end

endmodule

// File: tb/tb_mux_scan_serializer.sv
// tb_mux_scan_serializer
//   Directed bench for mux_scan_serializer. A 16-input instance and a
//   5-input instance each sit behind a behavioural mux built from a test
//   word. Inputs are driven and outputs sampled 1 time unit after each
//   rising edge.
module tb_mux_scan_serializer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- 16-input instance ----------------
  logic        start, msb_first, ser_ready;
  logic [3:0]  mux_sel;
  logic        mux_bit;
  logic        ser_out, ser_valid, ser_last, busy, done, parity;
  logic [15:0] word;

  assign mux_bit = word[mux_sel];

  mux_scan_serializer #(.N(16), .SEL_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .msb_first (msb_first),
    .mux_sel   (mux_sel),
    .mux_bit   (mux_bit),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .ser_last  (ser_last),
    .ser_ready (ser_ready),
    .busy      (busy),
    .done      (done),
    .parity    (parity)
  );

  // ---------------- 5-input instance ----------------
  logic       start5, msb5, ready5;
  logic [2:0] sel5;
  logic       bit5;
  logic       out5, valid5, last5, busy5, done5, parity5;
  logic [4:0] word5;

  assign bit5 = (sel5 < 3'd5) ? word5[sel5] : 1'bx;

  mux_scan_serializer #(.N(5), .SEL_W(3)) dut5 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start5),
    .msb_first (msb5),
    .mux_sel   (sel5),
    .mux_bit   (bit5),
    .ser_out   (out5),
    .ser_valid (valid5),
    .ser_last  (last5),
    .ser_ready (ready5),
    .busy      (busy5),
    .done      (done5),
    .parity    (parity5)
  );

  // ---------------- scoreboard counters ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full 16-bit frame. exp_s[k] is the k-th bit expected on the stream.
  // stall_at: bit index after which ser_ready is low for 3 cycles (-1: none).
  // restart_at: bit index at which start is pulsed mid-frame (-1: none).
  task automatic run_frame(input logic msb, input logic [15:0] exp_s, input logic exp_par,
                           input int stall_at, input int restart_at);
    logic [3:0] exp_sel;
    start     = 1'b1;
    msb_first = msb;
    tick();
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("sel_first", {28'd0, mux_sel}, msb ? 32'd15 : 32'd0);
    check("valid_before_first", {31'd0, ser_valid}, 32'd0);
    for (int k = 0; k < 16; k++) begin
      tick();
      start = 1'b0;
      if (msb) exp_sel = (k < 15) ? 4'(14 - k) : 4'd0;
      else     exp_sel = (k < 15) ? 4'(k + 1)  : 4'd15;
      check($sformatf("valid_b%0d", k), {31'd0, ser_valid}, 32'd1);
      check($sformatf("out_b%0d", k), {31'd0, ser_out}, {31'd0, exp_s[k]});
      check($sformatf("last_b%0d", k), {31'd0, ser_last}, (k == 15) ? 32'd1 : 32'd0);
      check($sformatf("sel_b%0d", k), {28'd0, mux_sel}, {28'd0, exp_sel});
      check($sformatf("busy_b%0d", k), {31'd0, busy}, 32'd1);
      if (k == restart_at) start = 1'b1;
      if (k == stall_at) begin
        ser_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          tick();
          check($sformatf("stall_valid_%0d", s), {31'd0, ser_valid}, 32'd1);
          check($sformatf("stall_out_%0d", s), {31'd0, ser_out}, {31'd0, exp_s[k]});
          check($sformatf("stall_sel_%0d", s), {28'd0, mux_sel}, {28'd0, exp_sel});
        end
        ser_ready = 1'b1;
      end
    end
    tick();
    start = 1'b0;
    check("valid_after_last", {31'd0, ser_valid}, 32'd0);
    check("done_pulse", {31'd0, done}, 32'd1);
    check("busy_in_done", {31'd0, busy}, 32'd0);
    check("parity", {31'd0, parity}, {31'd0, exp_par});
    tick();
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("parity_held", {31'd0, parity}, {31'd0, exp_par});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    msb_first = 1'b0;
    ser_ready = 1'b1;
    word      = 16'hA5C3;
    start5    = 1'b0;
    msb5      = 1'b0;
    ready5    = 1'b1;
    word5     = 5'b10110;

    tick();
    tick();
    check("rst_sel", {28'd0, mux_sel}, 32'd0);
    check("rst_valid", {31'd0, ser_valid}, 32'd0);
    check("rst_out", {31'd0, ser_out}, 32'd0);
    check("rst_last", {31'd0, ser_last}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_parity", {31'd0, parity}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_no_start", {31'd0, busy}, 32'd0);

    // A5C3, LSB first: 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1
    word = 16'hA5C3;
    run_frame(1'b0, 16'hA5C3, 1'b0, -1, -1);
    // A5C3, MSB first: 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1
    run_frame(1'b1, 16'hC3A5, 1'b0, -1, -1);
    // 0001, LSB first, stall after the 5th bit
    word = 16'h0001;
    run_frame(1'b0, 16'h0001, 1'b1, 4, -1);
    // start pulsed at the 8th bit is ignored; the next frame starts right
    // in the cycle after done
    word = 16'hA5C3;
    run_frame(1'b0, 16'hA5C3, 1'b0, -1, 7);
    run_frame(1'b1, 16'hC3A5, 1'b0, -1, -1);

    // Reset after the 7th bit of an A5C3 frame (ser_out=1, parity=1 then)
    word      = 16'hA5C3;
    start     = 1'b1;
    msb_first = 1'b0;
    tick();
    start = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    check("pre_rst_out", {31'd0, ser_out}, 32'd1);
    check("pre_rst_parity", {31'd0, parity}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, ser_valid}, 32'd0);
    check("mid_rst_out", {31'd0, ser_out}, 32'd0);
    check("mid_rst_last", {31'd0, ser_last}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_parity", {31'd0, parity}, 32'd0);
    check("mid_rst_sel", {28'd0, mux_sel}, 32'd0);
    tick();
    check("mid_rst_no_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_no_done", {31'd0, done}, 32'd0);
    check("post_rst_idle", {31'd0, busy}, 32'd0);
    word = 16'hFFFF;
    run_frame(1'b0, 16'hFFFF, 1'b0, -1, -1);

    // N=5 instance: 10110 LSB first -> 0,1,1,0,1
    start5 = 1'b1;
    tick();
    start5 = 1'b0;
    check("n5_sel_first", {29'd0, sel5}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("n5_valid_b%0d", k), {31'd0, valid5}, 32'd1);
      check($sformatf("n5_out_b%0d", k), {31'd0, out5}, {31'd0, word5[k]});
      check($sformatf("n5_last_b%0d", k), {31'd0, last5}, (k == 4) ? 32'd1 : 32'd0);
      check($sformatf("n5_sel_b%0d", k), {29'd0, sel5}, (k < 4) ? 32'(k + 1) : 32'd4);
    end
    tick();
    check("n5_done", {31'd0, done5}, 32'd1);
    check("n5_valid_off", {31'd0, valid5}, 32'd0);
    check("n5_parity", {31'd0, parity5}, 32'd1);
    check("n5_sel_range", {29'd0, sel5}, 32'd4);
    tick();
    check("n5_done_one_cycle", {31'd0, done5}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
